// File: rtl/seq_ep_pkg.sv
// Shared constants, types and elaboration helpers for the sequence endpoint tracker.
package seq_ep_pkg;

    localparam int unsigned DEF_N_CH  = 4;
    localparam int unsigned DEF_DELAY = 2;
    localparam int unsigned DEF_CNT_W = 8;

    // Counter type and saturation value at the default counter width
    typedef logic [DEF_CNT_W-1:0] cnt_t;
    localparam cnt_t SAT_MAX = '1;

    // Legal parameter combination: at least one channel, a nonzero a->b distance, a usable counter
    function automatic bit params_ok(input int unsigned n_ch, input int unsigned delay,
                                     input int unsigned cnt_w);
        return (n_ch >= 1) && (delay >= 1) && (cnt_w >= 2);
    endfunction

    // Width of the packed per-channel counter bus
    function automatic int unsigned slice_w(input int unsigned n_ch, input int unsigned cnt_w);
        return n_ch * cnt_w;
    endfunction

endpackage

// File: rtl/seq_endpoint_tracker_if.sv
// Stimulus/status bundle between a producer of sequence terms and the tracker.
interface seq_endpoint_tracker_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8
);
    logic                  src_tick;
    logic                  dst_tick;
    logic [N_CH-1:0]       a_i;
    logic [N_CH-1:0]       b_i;
    logic                  cnt_clr;
    logic [N_CH-1:0]       ended_o;
    logic [N_CH-1:0]       matched_o;
    logic [N_CH-1:0]       overrun_o;
    logic [N_CH*CNT_W-1:0] match_cnt_o;

    modport master (
        output src_tick, dst_tick, a_i, b_i, cnt_clr,
        input  ended_o, matched_o, overrun_o, match_cnt_o
    );

    modport slave (
        input  src_tick, dst_tick, a_i, b_i, cnt_clr,
        output ended_o, matched_o, overrun_o, match_cnt_o
    );
endinterface

// File: rtl/seq_ep_channel.sv
// One channel: a ##DELAY b detection, hold-until-consumed, overrun flag, saturating count.
module seq_ep_channel
    import seq_ep_pkg::*;
#(
    parameter int unsigned DELAY = DEF_DELAY,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_src_tick,
    input  logic             i_dst_tick,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_cnt_clr,
    output logic             o_ended,
    output logic             o_matched,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] L_SAT = '1;

    logic [DELAY-1:0] r_pend;
    logic             r_hold;
    logic             r_ended;
    logic             r_matched;
    logic             r_overrun;
    logic [CNT_W-1:0] r_cnt;

    logic             w_match;
    logic             w_consume;
    logic             w_hold_nxt;
    logic             w_ovr_nxt;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_nxt;

    // a-history shift register, advanced only on source ticks
    if (DELAY == 1) begin : g_pend_d1
        always_ff @(posedge clk or posedge rst) begin
            if (rst)             r_pend <= '0;
            else if (i_src_tick) r_pend <= i_a;
        end
    end else begin : g_pend_dn
        always_ff @(posedge clk or posedge rst) begin
            if (rst)             r_pend <= '0;
            else if (i_src_tick) r_pend <= {r_pend[DELAY-2:0], i_a};
        end
    end

    // Match detection, hold/consume, overrun and counter next-state
    always_comb begin
        w_match    = 1'b0;
        w_consume  = 1'b0;
        w_hold_nxt = r_hold;
        w_ovr_nxt  = r_overrun;
        w_cnt_base = r_cnt;
        w_cnt_nxt  = r_cnt;

        w_match   = i_src_tick & r_pend[DELAY-1] & i_b;
        // Only a hold that existed before this cycle can be consumed
        w_consume = i_dst_tick & r_hold;

        w_hold_nxt = w_match | (r_hold & ~w_consume);
        w_ovr_nxt  = (r_overrun & ~i_cnt_clr) | (w_match & r_hold & ~w_consume);

        w_cnt_base = i_cnt_clr ? '0 : r_cnt;
        w_cnt_nxt  = (w_match && (w_cnt_base != L_SAT)) ? (w_cnt_base + CNT_W'(1)) : w_cnt_base;
    end

    // Status and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= 1'b0;
            r_ended   <= 1'b0;
            r_matched <= 1'b0;
            r_overrun <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_hold    <= w_hold_nxt;
            r_ended   <= w_match;
            r_matched <= w_consume;
            r_overrun <= w_ovr_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign o_ended   = r_ended;
    assign o_matched = r_matched;
    assign o_overrun = r_overrun;
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/seq_endpoint_tracker.sv
// N-channel "a ##DELAY b" endpoint tracker with ended/matched pulses, overrun and counts.
module seq_endpoint_tracker
    import seq_ep_pkg::*;
#(
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned DELAY = DEF_DELAY,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_endpoint_tracker_if.slave bus
);

    localparam int unsigned L_CNT_BUS_W = slice_w(N_CH, CNT_W);

    // Reject illegal configurations at elaboration
    if (!params_ok(N_CH, DELAY, CNT_W)) begin : g_bad_params
        $error("seq_endpoint_tracker: need N_CH>=1, DELAY>=1, CNT_W>=2");
    end

    logic [N_CH-1:0]        w_ended;
    logic [N_CH-1:0]        w_matched;
    logic [N_CH-1:0]        w_overrun;
    logic [L_CNT_BUS_W-1:0] w_cnt;

    // One independent tracker per channel
    for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
        seq_ep_channel #(
            .DELAY (DELAY),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_src_tick (bus.src_tick),
            .i_dst_tick (bus.dst_tick),
            .i_a        (bus.a_i[c]),
            .i_b        (bus.b_i[c]),
            .i_cnt_clr  (bus.cnt_clr),
            .o_ended    (w_ended[c]),
            .o_matched  (w_matched[c]),
            .o_overrun  (w_overrun[c]),
            .o_cnt      (w_cnt[c*CNT_W +: CNT_W])
        );
    end

    assign bus.ended_o     = w_ended;
    assign bus.matched_o   = w_matched;
    assign bus.overrun_o   = w_overrun;
    assign bus.match_cnt_o = w_cnt;

endmodule

// File: tb/tb_seq_endpoint_tracker.sv
// Directed bench for seq_endpoint_tracker (N_CH=4, DELAY=2, CNT_W=8, src_tick every 2nd cycle).
module tb_seq_endpoint_tracker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    seq_endpoint_tracker_if #(.N_CH(4), .CNT_W(8)) bus ();

    seq_endpoint_tracker #(.N_CH(4), .DELAY(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One clock cycle with the given inputs; outputs are sampled 1ns after the edge
    task automatic step(input logic s, input logic d, input logic [3:0] a,
                        input logic [3:0] b, input logic clr);
        bus.src_tick = s;
        bus.dst_tick = d;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (bus.ended_o !== 4'h0) begin errs++; $display("FAIL rst_ended got=%b exp=0000", bus.ended_o); end
        vecs++; if (bus.matched_o !== 4'h0) begin errs++; $display("FAIL rst_matched got=%b exp=0000", bus.matched_o); end
        vecs++; if (bus.overrun_o !== 4'h0) begin errs++; $display("FAIL rst_overrun got=%b exp=0000", bus.overrun_o); end
        vecs++; if (bus.match_cnt_o !== 32'h0) begin errs++; $display("FAIL rst_cnt got=%h exp=00000000", bus.match_cnt_o); end
    endtask

    task automatic test_single();
        do_reset();
        step(1'b1, 1'b0, 4'h1, 4'h0, 1'b0);
        vecs++; if (bus.ended_o !== 4'h0) begin errs++; $display("FAIL single_early got=%b exp=0000", bus.ended_o); end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h1, 1'b0);
        vecs++; if (bus.ended_o !== 4'h1) begin errs++; $display("FAIL single_ended got=%b exp=0001", bus.ended_o); end
        vecs++; if (bus.match_cnt_o !== 32'h0000_0001) begin errs++; $display("FAIL single_cnt got=%h exp=00000001", bus.match_cnt_o); end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.ended_o !== 4'h0) begin errs++; $display("FAIL single_pulse_end got=%b exp=0000", bus.ended_o); end
    endtask

    task automatic test_overlap();
        do_reset();
        step(1'b1, 1'b0, 4'h2, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h2, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h2, 1'b0);
        vecs++; if (bus.ended_o !== 4'h2) begin errs++; $display("FAIL overlap_ended1 got=%b exp=0010", bus.ended_o); end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.ended_o !== 4'h0) begin errs++; $display("FAIL overlap_gap got=%b exp=0000", bus.ended_o); end
        step(1'b1, 1'b0, 4'h0, 4'h2, 1'b0);
        vecs++; if (bus.ended_o !== 4'h2) begin errs++; $display("FAIL overlap_ended2 got=%b exp=0010", bus.ended_o); end
        vecs++; if (bus.match_cnt_o !== 32'h0000_0200) begin errs++; $display("FAIL overlap_cnt got=%h exp=00000200", bus.match_cnt_o); end
    endtask

    task automatic test_matched();
        do_reset();
        // Match with a same-cycle dst_tick: that dst_tick must not consume it
        step(1'b1, 1'b0, 4'h4, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h0, 4'h4, 1'b0);
        vecs++; if (bus.ended_o !== 4'h4) begin errs++; $display("FAIL hold_ended got=%b exp=0100", bus.ended_o); end
        vecs++; if (bus.matched_o !== 4'h0) begin errs++; $display("FAIL hold_same_cycle got=%b exp=0000", bus.matched_o); end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.matched_o !== 4'h0) begin errs++; $display("FAIL hold_wait got=%b exp=0000", bus.matched_o); end
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.matched_o !== 4'h4) begin errs++; $display("FAIL hold_consume got=%b exp=0100", bus.matched_o); end
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.matched_o !== 4'h0) begin errs++; $display("FAIL hold_once got=%b exp=0000", bus.matched_o); end
        // Older hold consumed while a new match re-arms it
        do_reset();
        step(1'b1, 1'b0, 4'h4, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h4, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h4, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h0, 4'h4, 1'b0);
        vecs++; if (bus.matched_o !== 4'h4) begin errs++; $display("FAIL rearm_consume_old got=%b exp=0100", bus.matched_o); end
        vecs++; if (bus.overrun_o !== 4'h0) begin errs++; $display("FAIL rearm_no_overrun got=%b exp=0000", bus.overrun_o); end
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.matched_o !== 4'h4) begin errs++; $display("FAIL rearm_consume_new got=%b exp=0100", bus.matched_o); end
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.matched_o !== 4'h0) begin errs++; $display("FAIL rearm_empty got=%b exp=0000", bus.matched_o); end
    endtask

    task automatic test_overrun();
        do_reset();
        step(1'b1, 1'b0, 4'h8, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h8, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h8, 1'b0);
        vecs++; if (bus.overrun_o !== 4'h0) begin errs++; $display("FAIL ovr_first got=%b exp=0000", bus.overrun_o); end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h8, 1'b0);
        vecs++; if (bus.overrun_o !== 4'h8) begin errs++; $display("FAIL ovr_set got=%b exp=1000", bus.overrun_o); end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.matched_o !== 4'h8) begin errs++; $display("FAIL ovr_matched got=%b exp=1000", bus.matched_o); end
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.matched_o !== 4'h0) begin errs++; $display("FAIL ovr_single_pulse got=%b exp=0000", bus.matched_o); end
        vecs++; if (bus.overrun_o !== 4'h8) begin errs++; $display("FAIL ovr_sticky got=%b exp=1000", bus.overrun_o); end
        vecs++; if (bus.match_cnt_o !== 32'h0200_0000) begin errs++; $display("FAIL ovr_cnt got=%h exp=02000000", bus.match_cnt_o); end
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        vecs++; if (bus.overrun_o !== 4'h0) begin errs++; $display("FAIL ovr_clr got=%b exp=0000", bus.overrun_o); end
        vecs++; if (bus.match_cnt_o !== 32'h0) begin errs++; $display("FAIL ovr_cnt_clr got=%h exp=00000000", bus.match_cnt_o); end
    endtask

    task automatic test_saturate();
        do_reset();
        // a and b held high: matches on ticks 3..262 = 260 matches
        for (int i = 1; i <= 262; i++) begin
            step(1'b1, 1'b0, 4'h1, 4'h1, 1'b0);
            if (i == 3) begin
                vecs++; if (bus.match_cnt_o[7:0] !== 8'd1) begin errs++; $display("FAIL sat_first got=%0d exp=1", bus.match_cnt_o[7:0]); end
            end
            if (i == 257) begin
                vecs++; if (bus.match_cnt_o[7:0] !== 8'd255) begin errs++; $display("FAIL sat_reach got=%0d exp=255", bus.match_cnt_o[7:0]); end
            end
            step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        end
        vecs++; if (bus.match_cnt_o !== 32'h0000_00ff) begin errs++; $display("FAIL sat_hold got=%h exp=000000ff", bus.match_cnt_o); end
        step(1'b1, 1'b0, 4'h1, 4'h1, 1'b1);
        vecs++; if (bus.match_cnt_o !== 32'h0000_0001) begin errs++; $display("FAIL sat_clr_match got=%h exp=00000001", bus.match_cnt_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b0, 4'h1, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h1, 1'b0);
        vecs++; if (bus.ended_o !== 4'h0) begin errs++; $display("FAIL rstmid_ended got=%b exp=0000", bus.ended_o); end
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        vecs++; if (bus.matched_o !== 4'h0) begin errs++; $display("FAIL rstmid_matched got=%b exp=0000", bus.matched_o); end
        vecs++; if (bus.match_cnt_o !== 32'h0) begin errs++; $display("FAIL rstmid_cnt got=%h exp=00000000", bus.match_cnt_o); end
    endtask

    initial begin
        bus.src_tick = 1'b0;
        bus.dst_tick = 1'b0;
        bus.a_i      = 4'h0;
        bus.b_i      = 4'h0;
        bus.cnt_clr  = 1'b0;
        test_reset();
        test_single();
        test_overlap();
        test_matched();
        test_overrun();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/seq_endpoint_tracker.md
Name: seq_endpoint_tracker

Overview:
N-channel hardware endpoint detector for the two-step sequence "a ##DELAY b", sampled on a source tick enable. Each channel reports two results. The "ended" result is a pulse on the source tick where the sequence completes. The "matched" result holds the endpoint until the first destination tick strictly after the match, then reports it. It sits beside the assertion/coverage harnesses, turning sequence endpoints into synthesizable status, per-channel match counts and overrun flags. Both tick domains are modelled as enables on one clock.

Parameters:
N_CH, 4, number of independent channels (>=1)
DELAY, 2, source-tick distance from a to b (>=1; elaboration error if 0)
CNT_W, 8, width of the per-channel saturating match counter (>=2)

Ports:
clk  input  1  single system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
src_tick  input  1  source sampling enable (sysclk-equivalent tick)
dst_tick  input  1  destination sampling enable (consumer tick)
a_i  input  N_CH  per-channel first sequence term
b_i  input  N_CH  per-channel second sequence term
cnt_clr  input  1  synchronous clear of all counters and overrun flags
ended_o  output  N_CH  one-cycle pulse per completed match (ended semantics)
matched_o  output  N_CH  one-cycle pulse when a held match is consumed by dst_tick
overrun_o  output  N_CH  sticky flag: new match arrived while a prior one was unconsumed
match_cnt_o  output  N_CH*CNT_W  packed saturating match counters, channel 0 in LSBs

Behaviour:
- Reset (async assert, sync-safe release): all outputs, pending shift registers, hold flags, counters and overrun flags = 0. Reset mid-sequence discards all in-flight attempts.
- a_i/b_i are only sampled in cycles with src_tick=1. Cycles without src_tick leave pending state unchanged.
- Per channel, pend[DELAY-1:0] shifts on src_tick: pend[0] <= a_i[c].
- Match at cycle t: src_tick=1, pend[DELAY-1]=1 (a seen DELAY ticks ago) and b_i[c]=1. The pre-shift value is used.
- Overlapping attempts are independent: a on consecutive ticks plus b on consecutive ticks gives consecutive matches.
- ended_o[c] = registered match; it pulses in cycle t+1. Latency 1.
- Hold flag: set by a match at t and visible from t+1.
- A dst_tick at cycle u consumes the hold only if the hold was set before u (u > t). matched_o[c] pulses at u+1 and the hold clears.
- A match and a dst_tick in the same cycle: the dst_tick does not consume that match.
  - If an older hold exists, it is consumed (matched_o pulses) and the new match re-arms the hold.
- A match while the hold is set and no consuming dst_tick occurs in that cycle: overrun_o[c] <= 1 (sticky). The hold stays set; only one matched pulse results.
- Counter: +1 per match, saturates at 2^CNT_W-1, never wraps.
- cnt_clr has priority over the increment, then the match is counted: cnt_clr plus a match in the same cycle gives a count of 1. cnt_clr also clears overrun_o. It does not affect pend or the hold.
- src_tick and dst_tick may be high in the same cycle; all rules above apply independently.

Decomposition:
- Package seq_ep_pkg holds:
  - the DELAY/CNT_W legality check function
  - the cnt_t typedef helper
  - the constants SAT_MAX and a channel-slice width function
- Sub-module seq_ep_channel (one channel: pend shift register, match logic, hold, overrun, counter) is instantiated N_CH times by a generate loop in the top.

Test Plan:
All scenarios use N_CH=4, DELAY=2, CNT_W=8, with src_tick every 2nd cycle.
1. a_i[0]=1 at tick 1, b_i[0]=1 at tick 3 -> ended_o[0] pulses the cycle after tick 3; match_cnt_o[7:0]=1. Other channels stay 0.
2. a_i[1]=1 at ticks 1 and 2, b_i[1]=1 at ticks 3 and 4 -> two ended_o[1] pulses; count=2.
3. Match on ch2, dst_tick 3 cycles later -> exactly one matched_o[2] pulse, one cycle after that dst_tick. A dst_tick in the same cycle as the match gives no pulse; the next dst_tick gives the pulse.
4. Two matches on ch3 with no dst_tick between them -> overrun_o[3]=1 (sticky), a single matched_o[3] on the next dst_tick. cnt_clr -> overrun_o[3]=0 and count=0.
5. 260 matches on ch0 -> count holds 255. cnt_clr together with a match -> count=1.
6. a_i[0]=1 at tick 1, then rst pulse before tick 3, then b_i[0]=1 at tick 3 -> no ended_o, no matched_o, count=0.
